// File: rtl/fsb_node_trace_replay.sv
// Trace-driven stimulus/checker: walks a combinational trace ROM of {opcode, payload} words,
// sending packets, checking returned packets and timing waits, with sticky done/error flags.
module fsb_node_trace_replay #(
  parameter int unsigned ring_width_p     = 32,
  parameter int unsigned rom_addr_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        en_i,
  input  logic                        v_i,
  input  logic [ring_width_p-1:0]     data_i,
  output logic                        ready_o,
  output logic                        v_o,
  output logic [ring_width_p-1:0]     data_o,
  input  logic                        yumi_i,
  output logic [rom_addr_width_p-1:0] rom_addr_o,
  input  logic [ring_width_p+3:0]     rom_data_i,
  output logic                        done_o,
  output logic                        error_o
);

  typedef enum logic [3:0] {
    OpNop       = 4'd0,
    OpSend      = 4'd1,
    OpRecv      = 4'd2,
    OpDone      = 4'd3,
    OpFinish    = 4'd4,
    OpCycleInit = 4'd5,
    OpCycleWait = 4'd6
  } op_e;

  logic [rom_addr_width_p-1:0] addr_r;
  logic [rom_addr_width_p-1:0] addr_inc;
  logic [ring_width_p-1:0]     cnt_r;
  logic                        halt_r;
  logic                        done_r;
  logic                        error_r;

  logic [3:0]              op;
  logic [ring_width_p-1:0] pl;
  logic                    active;

  assign op       = rom_data_i[ring_width_p+3:ring_width_p];
  assign pl       = rom_data_i[ring_width_p-1:0];
  assign addr_inc = addr_r + rom_addr_width_p'(1);

  // Gating with reset_i keeps v_o/ready_o low for the whole asynchronous reset window.
  assign active = reset_i & en_i & ~halt_r;

  assign v_o        = active & (op == OpSend);
  assign ready_o    = active & (op == OpRecv);
  assign data_o     = pl;
  assign rom_addr_o = addr_r;
  assign done_o     = done_r;
  assign error_o    = error_r;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      addr_r  <= '0;
      cnt_r   <= '0;
      halt_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else if (active) begin
      unique case (op)
        OpNop: addr_r <= addr_inc;
        OpSend: begin
          if (yumi_i) addr_r <= addr_inc;
        end
        OpRecv: begin
          // A mismatch is recorded but never stalls the trace.
          if (v_i) begin
            addr_r <= addr_inc;
            if (data_i != pl) error_r <= 1'b1;
          end
        end
        OpDone: begin
          done_r <= 1'b1;
          addr_r <= addr_inc;
        end
        OpFinish: begin
          done_r <= 1'b1;
          halt_r <= 1'b1;
        end
        OpCycleInit: begin
          cnt_r  <= pl;
          addr_r <= addr_inc;
        end
        OpCycleWait: begin
          if (cnt_r == '0) addr_r <= addr_inc;
          else             cnt_r  <= cnt_r - ring_width_p'(1);
        end
        default: begin
          error_r <= 1'b1;
          halt_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsb_node_trace_replay.sv
// Bench for fsb_node_trace_replay: random traces replayed against a loopback squarer, with a
// trace-level reference model feeding scoreboard queues that a negedge monitor drains.
module tb_fsb_node_trace_replay;

  localparam int W  = 32;
  localparam int AW = 32;

  localparam logic [3:0] NOP = 4'd0, SEND = 4'd1, RECV = 4'd2, DONE = 4'd3;
  localparam logic [3:0] FINISH = 4'd4, INIT = 4'd5, WAIT = 4'd6;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          v_in;
  logic [W-1:0]  data_in;
  logic          ready_out;
  logic          v_out;
  logic [W-1:0]  data_out;
  logic          yumi;
  logic [AW-1:0] rom_addr;
  logic [W+3:0]  rom_data;
  logic          done;
  logic          error;

  logic [W+3:0]  rom [64];
  assign rom_data = rom[rom_addr[5:0]];

  always #5 clk = ~clk;

  fsb_node_trace_replay #(
    .ring_width_p     (W),
    .rom_addr_width_p (AW)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .en_i       (en),
    .v_i        (v_in),
    .data_i     (data_in),
    .ready_o    (ready_out),
    .v_o        (v_out),
    .data_o     (data_out),
    .yumi_i     (yumi),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .done_o     (done),
    .error_o    (error)
  );

  typedef struct {
    int unsigned addr;
    int unsigned cycles;
    logic        done;
    logic        err;
  } ent_t;

  ent_t        entq[$];
  logic [W-1:0] sendq[$];

  // Trace program: body entries 0..p_n-1, terminator at p_n.
  logic [3:0]  p_op  [64];
  logic [W-1:0] p_pl [64];
  int unsigned p_dly [64];
  int unsigned p_n;
  logic [3:0]  p_term;
  logic        exp_done;
  logic        exp_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder / monitor state
  logic [AW-1:0] drv_addr;
  int unsigned   hs;
  logic [W-1:0]  last_sent;
  logic          mon_on = 1'b0;
  logic [AW-1:0] mon_addr;
  int unsigned   mon_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic put(input int unsigned i, input logic [3:0] op, input logic [W-1:0] pl,
                     input int unsigned dly);
    p_op[i]  = op;
    p_pl[i]  = pl;
    p_dly[i] = dly;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) put(i, NOP, '0, 0);
  endtask

  task automatic build_directed();
    clear_prog();
    put(0, SEND, 32'h5, 3);
    put(1, RECV, 32'd25, 0);
    put(2, RECV, 32'd24, 1);
    put(3, INIT, 32'd3, 0);
    put(4, WAIT, 32'h0, 0);
    put(5, NOP, 32'hdead_beef, 0);
    put(6, DONE, 32'h0, 0);
    put(7, SEND, 32'h2, 2);
    put(8, RECV, 32'h4, 0);
    put(9, DONE, 32'h0, 0);
    p_n    = 10;
    p_term = FINISH;
  endtask

  task automatic build_random(input int force_term);
    logic [W-1:0] last;
    logic [W-1:0] sq;
    int unsigned  k;
    clear_prog();
    last = '0;
    p_n  = $urandom_range(4, 16);
    for (int unsigned i = 0; i < p_n; i++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: put(i, NOP, $urandom, 0);
        1: begin
          put(i, SEND, $urandom, $urandom_range(0, 3));
          last = p_pl[i];
        end
        2: begin
          sq = last * last;
          if ($urandom_range(0, 3) == 0) sq = sq ^ 32'h1;
          put(i, RECV, sq, $urandom_range(0, 3));
        end
        3: put(i, DONE, $urandom, 0);
        4: put(i, INIT, $urandom_range(0, 5), 0);
        default: put(i, WAIT, $urandom, 0);
      endcase
    end
    if (force_term >= 0) p_term = 4'(force_term);
    else if ($urandom_range(0, 3) == 0) p_term = 4'($urandom_range(7, 15));
    else p_term = FINISH;
  endtask

  // Reference model: trace semantics with plain integer bookkeeping.
  task automatic load_and_model();
    int unsigned  cnt;
    logic         d;
    logic         e;
    logic [W-1:0] last;
    logic [W-1:0] sq;
    ent_t         ent;
    for (int i = 0; i < 64; i++) rom[i] = '0;
    for (int unsigned i = 0; i < p_n; i++) rom[i] = {p_op[i], p_pl[i]};
    rom[p_n] = {p_term, W'($urandom)};
    cnt = 0; d = 1'b0; e = 1'b0; last = '0;
    entq.delete();
    sendq.delete();
    for (int unsigned i = 0; i < p_n; i++) begin
      ent.cycles = 1;
      case (p_op[i])
        SEND: begin
          ent.cycles = p_dly[i] + 1;
          sendq.push_back(p_pl[i]);
          last = p_pl[i];
        end
        RECV: begin
          ent.cycles = p_dly[i] + 1;
          sq = last * last;
          if (p_pl[i] != sq) e = 1'b1;
        end
        DONE: d = 1'b1;
        INIT: cnt = int'(p_pl[i]);
        WAIT: begin
          ent.cycles = cnt + 1;
          cnt = 0;
        end
        default: ;
      endcase
      ent.addr = i;
      ent.done = d;
      ent.err  = e;
      entq.push_back(ent);
    end
    exp_done = (p_term == FINISH) ? 1'b1 : d;
    exp_err  = (p_term == FINISH) ? e : 1'b1;
  endtask

  // One cycle of stimulus, entered at posedge+1. Acts as a loopback squarer with per-entry delay.
  task automatic drive_cycle();
    en      = ($urandom_range(0, 3) != 0);
    yumi    = 1'b0;
    v_in    = 1'b0;
    data_in = $urandom;
    #1;
    if (rom_addr != drv_addr) begin
      drv_addr = rom_addr;
      hs = 0;
    end
    if (v_out) begin
      if (hs == p_dly[drv_addr[5:0]]) begin
        yumi = 1'b1;
        last_sent = data_out;
      end else hs++;
    end else if (ready_out) begin
      if (hs == p_dly[drv_addr[5:0]]) begin
        v_in    = 1'b1;
        data_in = last_sent * last_sent;
      end else hs++;
    end else begin
      v_in = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_prog();
    int  post;
    logic finished;
    load_and_model();
    reset = 1'b0;
    en    = 1'b1;
    yumi  = 1'b0;
    v_in  = 1'b0;
    #1;
    chk("rst_addr", rom_addr, 0);
    chk("rst_v_o", v_out, 0);
    chk("rst_ready_o", ready_out, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    drv_addr  = '0;
    hs        = 0;
    last_sent = '0;
    mon_addr  = '0;
    mon_cyc   = 0;
    mon_on    = 1'b1;
    post      = 0;
    finished  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (entq.size() == 0 && sendq.size() == 0) begin
        post++;
        if (post > 8) begin
          finished = 1'b1;
          break;
        end
      end
      drive_cycle();
      @(posedge clk);
      #1;
    end
    mon_on = 1'b0;
    if (!finished) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got %0d entries pending, expected 0", entq.size());
    end
    en   = 1'b1;
    yumi = 1'b0;
    #1;
    chk("halt_addr", rom_addr, p_n);
    chk("halt_v_o", v_out, 0);
    chk("halt_ready_o", ready_out, 0);
    chk("final_done", done, exp_done);
    chk("final_error", error, exp_err);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (rom_addr != mon_addr) begin
        if (entq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_advance: got addr 0x%0h, expected 0x%0h", rom_addr, mon_addr);
        end else begin
          ent_t e;
          e = entq.pop_front();
          chk("entry_addr", mon_addr, e.addr);
          chk("entry_cycles", mon_cyc, e.cycles);
          chk("done_after", done, e.done);
          chk("error_after", error, e.err);
        end
        mon_addr = rom_addr;
        mon_cyc  = 0;
      end
      if (en) mon_cyc++;
      if (v_out && ready_out) chk("send_recv_exclusive", 1, 0);
      if (v_out && yumi) begin
        if (sendq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_send: got 0x%0h, expected none", data_out);
        end else chk("send_data", data_out, sendq.pop_front());
      end
    end
  end

  initial begin
    reset   = 1'b0;
    en      = 1'b0;
    v_in    = 1'b0;
    yumi    = 1'b0;
    data_in = '0;
    for (int i = 0; i < 64; i++) rom[i] = '0;

    // Asynchronous reset in the middle of a pending SEND.
    rom[0] = {NOP, 32'h0};
    rom[1] = {NOP, 32'h0};
    rom[2] = {SEND, 32'h5};
    en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_send_addr", rom_addr, 2);
    chk("mid_send_v_o", v_out, 1);
    chk("mid_send_data", data_out, 32'h5);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_v_o", v_out, 0);
    chk("async_rst_addr", rom_addr, 0);

    build_directed();
    run_prog();
    build_random(15);
    run_prog();
    for (int r = 0; r < 20; r++) begin
      build_random(-1);
      run_prog();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
